// File: rtl/core_pkg.sv
// Shared definitions for the myrv multi-cycle core: sequencer states, bus and
// PC mux selects, and the writeback-select encoding used by the decoder.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5
  } state_e;

  localparam logic SEL_PC    = 1'b0;
  localparam logic SEL_ALU   = 1'b1;

  localparam logic PC_PLUS4  = 1'b0;
  localparam logic PC_TARGET = 1'b1;

  // Writeback source; anything other than WB_NONE writes the register file.
  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_LINK = 2'd1;
  localparam logic [1:0] WB_ALU  = 2'd2;
  localparam logic [1:0] WB_LOAD = 2'd3;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: free-running modulo 2^CNT_W, advances when inc=1.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the myrv core: fetch, decode, execute, optional
// memory access and writeback, with bus handshake and write-enable generation.
module core_sequencer
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             bus_ack,
  input  logic             mem,
  input  logic             mem_read,
  input  logic             branch,
  input  logic             jump,
  input  logic [1:0]       wb,
  input  logic             taken,
  output logic             bus_req,
  output logic             bus_we,
  output logic             bus_sel_data,
  output logic             ir_we,
  output logic             alu_we,
  output logic             ld_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_e state_q, state_d;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Outputs are Mealy on bus_ack so zero-wait acks retire the request in the
  // same cycle; the request holds until the ack because state only moves then.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_sel_data = SEL_PC;
    ir_we        = 1'b0;
    alu_we       = 1'b0;
    ld_we        = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    retire       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus_req      = 1'b1;
        bus_sel_data = SEL_PC;
        if (bus_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_we  = 1'b1;
        state_d = mem ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        bus_req      = 1'b1;
        bus_sel_data = SEL_ALU;
        bus_we       = !mem_read;
        if (bus_ack) begin
          ld_we   = mem_read;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rf_we   = (wb != WB_NONE);
        pc_we   = 1'b1;
        pc_sel  = (branch && (jump || taken)) ? PC_TARGET : PC_PLUS4;
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state = state_q;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: walks ALU, load, store, branch and jump
// instructions cycle by cycle, plus run-drop, async reset and counter wrap.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, bus_ack, mem, mem_read, branch, jump, taken;
  logic [1:0]  wb;
  logic        bus_req, bus_we, bus_sel_data, ir_we, alu_we, ld_we;
  logic        rf_we, pc_we, pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  // Narrow twin fed the same stimulus, so the counter wrap is reachable.
  logic        s_bus_req, s_bus_we, s_bus_sel_data, s_ir_we, s_alu_we, s_ld_we;
  logic        s_rf_we, s_pc_we, s_pc_sel;
  logic [2:0]  s_state;
  logic [1:0]  s_instret;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .bus_ack(bus_ack), .mem(mem),
    .mem_read(mem_read), .branch(branch), .jump(jump), .wb(wb), .taken(taken),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel_data(bus_sel_data),
    .ir_we(ir_we), .alu_we(alu_we), .ld_we(ld_we), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .state(state), .instret(instret)
  );

  core_sequencer #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .run(run), .bus_ack(bus_ack), .mem(mem),
    .mem_read(mem_read), .branch(branch), .jump(jump), .wb(wb), .taken(taken),
    .bus_req(s_bus_req), .bus_we(s_bus_we), .bus_sel_data(s_bus_sel_data),
    .ir_we(s_ir_we), .alu_we(s_alu_we), .ld_we(s_ld_we), .rf_we(s_rf_we),
    .pc_we(s_pc_we), .pc_sel(s_pc_sel), .state(s_state), .instret(s_instret)
  );

  // Strobe order: req, we, sel_data, ir_we, alu_we, ld_we, rf_we, pc_we, pc_sel
  localparam logic [8:0] ST_NONE   = 9'b000_000_000;
  localparam logic [8:0] ST_FWAIT  = 9'b100_000_000;
  localparam logic [8:0] ST_FACK   = 9'b100_100_000;
  localparam logic [8:0] ST_EXEC   = 9'b000_010_000;
  localparam logic [8:0] ST_LDWAIT = 9'b101_000_000;
  localparam logic [8:0] ST_LDACK  = 9'b101_001_000;
  localparam logic [8:0] ST_STORE  = 9'b111_000_000;
  localparam logic [8:0] ST_WB_RF  = 9'b000_000_110;
  localparam logic [8:0] ST_WB     = 9'b000_000_010;
  localparam logic [8:0] ST_WB_TGT = 9'b000_000_011;
  localparam logic [8:0] ST_WB_JAL = 9'b000_000_111;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Lets the freshly driven inputs settle, then compares state plus strobes.
  task automatic chk(input string tag, input state_e exp_st, input logic [8:0] exp_sb);
    logic [11:0] obs, exp;
    #1;
    obs = {state, bus_req, bus_we, bus_sel_data, ir_we, alu_we, ld_we,
           rf_we, pc_we, pc_sel};
    exp = {exp_st, exp_sb};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic m, input logic mr, input logic br,
                         input logic jp, input logic tk, input logic [1:0] w);
    mem = m; mem_read = mr; branch = br; jump = jp; taken = tk; wb = w;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; bus_ack = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_NONE);
    #2;
    chk("reset_outputs", S_IDLE, ST_NONE);
    chk_cnt("reset_instret", instret, 32'd0);

    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    chk("idle_run", S_IDLE, ST_NONE);

    // ALU instruction, zero-wait fetch
    adv(); bus_ack = 1'b1; set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU);
    chk("alu_fetch", S_FETCH, ST_FACK);
    adv(); bus_ack = 1'b0;
    chk("alu_decode", S_DECODE, ST_NONE);
    adv();
    chk("alu_exec", S_EXECUTE, ST_EXEC);
    adv();
    chk("alu_wb", S_WRITEBACK, ST_WB_RF);
    chk_cnt("alu_instret_before", instret, 32'd0);

    // Load with three wait cycles in MEM
    adv(); bus_ack = 1'b1; set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, WB_LOAD);
    chk("ld_fetch", S_FETCH, ST_FACK);
    chk_cnt("alu_instret_after", instret, 32'd1);
    adv(); bus_ack = 1'b0;
    chk("ld_decode", S_DECODE, ST_NONE);
    adv();
    chk("ld_exec", S_EXECUTE, ST_EXEC);
    adv();
    chk("ld_mem_wait1", S_MEM, ST_LDWAIT);
    adv();
    chk("ld_mem_wait2", S_MEM, ST_LDWAIT);
    adv();
    chk("ld_mem_wait3", S_MEM, ST_LDWAIT);
    adv(); bus_ack = 1'b1;
    chk("ld_mem_ack", S_MEM, ST_LDACK);
    adv(); bus_ack = 1'b0;
    chk("ld_wb", S_WRITEBACK, ST_WB_RF);

    // Store; a stray ack during DECODE must be ignored
    adv(); bus_ack = 1'b1; set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, WB_NONE);
    chk("st_fetch", S_FETCH, ST_FACK);
    chk_cnt("ld_instret", instret, 32'd2);
    adv();
    chk("st_decode_stray_ack", S_DECODE, ST_NONE);
    adv(); bus_ack = 1'b0;
    chk("st_exec", S_EXECUTE, ST_EXEC);
    adv(); bus_ack = 1'b1;
    chk("st_mem_ack", S_MEM, ST_STORE);
    adv(); bus_ack = 1'b0;
    chk("st_wb", S_WRITEBACK, ST_WB);

    // Branch not taken
    adv(); bus_ack = 1'b1; set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WB_NONE);
    chk("bnt_fetch", S_FETCH, ST_FACK);
    chk_cnt("st_instret", instret, 32'd3);
    chk_cnt("small_instret_3", {30'd0, s_instret}, 32'd3);
    adv(); bus_ack = 1'b0;
    adv();
    chk("bnt_exec", S_EXECUTE, ST_EXEC);
    adv();
    chk("bnt_wb", S_WRITEBACK, ST_WB);

    // Branch taken; narrow counter wraps 3 -> 0 on this retirement
    adv(); bus_ack = 1'b1; set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, WB_NONE);
    chk("bt_fetch", S_FETCH, ST_FACK);
    chk_cnt("bnt_instret", instret, 32'd4);
    chk_cnt("small_instret_wrap", {30'd0, s_instret}, 32'd0);
    adv(); bus_ack = 1'b0;
    adv();
    adv();
    chk("bt_wb", S_WRITEBACK, ST_WB_TGT);

    // JAL with link write
    adv(); bus_ack = 1'b1; set_dec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, WB_LINK);
    chk("jal_fetch", S_FETCH, ST_FACK);
    adv(); bus_ack = 1'b0;
    adv();
    adv();
    chk("jal_wb", S_WRITEBACK, ST_WB_JAL);

    // Drop run while the fetch waits; instruction still completes
    adv(); set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU);
    chk("drop_fetch_wait1", S_FETCH, ST_FWAIT);
    chk_cnt("jal_instret", instret, 32'd6);
    adv(); run = 1'b0;
    chk("drop_fetch_wait2", S_FETCH, ST_FWAIT);
    adv(); bus_ack = 1'b1;
    chk("drop_fetch_ack", S_FETCH, ST_FACK);
    adv(); bus_ack = 1'b0;
    chk("drop_decode", S_DECODE, ST_NONE);
    adv();
    chk("drop_exec", S_EXECUTE, ST_EXEC);
    adv();
    chk("drop_wb", S_WRITEBACK, ST_WB_RF);
    adv(); bus_ack = 1'b1;
    chk("drop_idle", S_IDLE, ST_NONE);
    chk_cnt("drop_instret", instret, 32'd7);
    adv(); run = 1'b1; bus_ack = 1'b0;
    chk("idle_rerun", S_IDLE, ST_NONE);
    adv(); bus_ack = 1'b1; set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, WB_LOAD);
    chk("rerun_fetch", S_FETCH, ST_FACK);

    // Async reset in the middle of a MEM wait
    adv(); bus_ack = 1'b0;
    adv();
    adv();
    chk("rst_mem_wait", S_MEM, ST_LDWAIT);
    rst_n = 1'b0;
    chk("rst_async_outputs", S_IDLE, ST_NONE);
    chk_cnt("rst_async_instret", instret, 32'd0);
    adv();
    chk("rst_held", S_IDLE, ST_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    adv();
    chk("rst_release_fetch", S_FETCH, ST_FWAIT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
